// File: rtl/quat_result_packer.sv
// Rounds and saturates the four 32-bit quaternion product components to 16 bits,
// buffers whole quaternions in a small FIFO and serializes them one component per beat.
module quat_result_packer #(
    parameter int FRAC  = 14,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] q0,
    input  logic signed [31:0] q1,
    input  logic signed [31:0] q2,
    input  logic signed [31:0] q3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_data,
    output logic [1:0]         out_idx,
    output logic               out_last,
    output logic               sat_flag,
    output logic [15:0]        sat_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic signed [32:0] HALF = 33'sd1 <<< (FRAC - 1);

    logic [15:0]   r_mem    [DEPTH][4];
    logic [3:0]    r_satMem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic [1:0]    r_idx;
    logic [15:0]   r_satCount;

    logic signed [31:0] w_q    [4];
    logic [15:0]        w_conv [4];
    logic [3:0]         w_sat;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_beat;
    logic               w_pop;

    // Widened to 33 bits so adding the rounding half can never wrap.
    function automatic logic [16:0] convert(input logic signed [31:0] q);
        logic signed [32:0] w_sum;
        logic signed [32:0] w_round;
        w_sum   = $signed({q[31], q}) + HALF;
        w_round = w_sum >>> FRAC;
        if (w_round > 33'sd32767)
            convert = {1'b1, 16'h7FFF};
        else if (w_round < -33'sd32768)
            convert = {1'b1, 16'h8000};
        else
            convert = {1'b0, w_round[15:0]};
    endfunction

    assign w_q[0] = q0;
    assign w_q[1] = q1;
    assign w_q[2] = q2;
    assign w_q[3] = q3;

    always_comb begin
        w_sat = '0;
        for (int k = 0; k < 4; k++) begin
            w_conv[k] = '0;
            {w_sat[k], w_conv[k]} = convert(w_q[k]);
        end
    end

    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = !rst || !w_full;
    assign out_valid = rst && !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_beat    = out_valid && out_ready;
    assign w_pop     = w_beat && (r_idx == 2'd3);
    assign sat_count = r_satCount;

    always_comb begin
        out_data = '0;
        out_idx  = '0;
        out_last = 1'b0;
        sat_flag = 1'b0;
        if (out_valid) begin
            out_data = r_mem[r_rdPtr][r_idx];
            out_idx  = r_idx;
            out_last = (r_idx == 2'd3);
            sat_flag = r_satMem[r_rdPtr][r_idx];
        end
    end

    // Storage is left uncleared on reset; pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_satCount <= '0;
        end else begin
            if (w_push) begin
                for (int k = 0; k < 4; k++)
                    r_mem[r_wrPtr][k] <= w_conv[k];
                r_satMem[r_wrPtr] <= w_sat;
                r_wrPtr           <= r_wrPtr + PW'(1);
                if ((|w_sat) && (r_satCount != 16'hFFFF))
                    r_satCount <= r_satCount + 16'd1;
            end
            if (w_beat)
                r_idx <= r_idx + 2'd1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (PW+1)'(1);
        end
    end

endmodule

// File: doc/quat_result_packer.md
QUAT_RESULT_PACKER -- requirements
Module: quat_result_packer

Interface
REQ-001 Parameter FRAC, default 14: number of fractional bits dropped when converting a 32-bit product component to 16-bit; legal range 1..16.
REQ-002 Parameter DEPTH, default 4: quaternion FIFO depth in entries; power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream quaternion q0..q3 is valid this cycle.
REQ-006 in_ready  output  1  block can accept a quaternion this cycle.
REQ-007 q0, q1, q2, q3  input  32 each, signed  Hamilton-product components from the quaternion multiplier stage.
REQ-008 out_valid  output  1  out_data carries a valid component.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  16, signed  rounded and saturated component.
REQ-011 out_idx  output  2  index (0..3) of the component on out_data.
REQ-012 out_last  output  1  high when out_idx == 3.
REQ-013 sat_flag  output  1  the component on out_data was saturated.
REQ-014 sat_count  output  16  count of accepted quaternions with at least one saturated component.

Function
REQ-015 Input accept: the block SHALL accept a quaternion on a rising edge when in_valid && in_ready.
REQ-016 in_ready SHALL equal "FIFO not full" and SHALL NOT depend on out_ready; there is no push-when-full-while-popping.
REQ-017 Conversion per component SHALL be r = (q + 2^(FRAC-1)) >>> FRAC, evaluated in at least 33 signed bits (round half toward +inf, no wrap on the add).
REQ-018 If r > 32767, the stored value SHALL be 32767; if r < -32768, it SHALL be -32768; otherwise it SHALL be r[15:0]. Each saturation SHALL set that component's stored sat bit.
REQ-019 Each FIFO entry SHALL hold 4x16-bit values plus 4 sat bits, written at accept time.
REQ-020 FIFO SHALL use read/write pointers with wrap-around at DEPTH, plus an occupancy count of 0..DEPTH. Full SHALL be count == DEPTH; empty SHALL be count == 0.
REQ-021 Latency: a quaternion accepted on edge N SHALL make out_valid high in the cycle after edge N (registered FIFO, no combinational bypass) if the FIFO was empty.
REQ-022 Serializer: out_valid SHALL equal "FIFO not empty". out_data, out_idx and sat_flag SHALL present the head entry's component selected by the idx counter.
REQ-023 On out_valid && out_ready, idx SHALL increment. When idx == 3, idx SHALL return to 0 and the head entry SHALL be popped on the same edge.
REQ-024 While out_valid is low, out_data, out_idx, out_last and sat_flag SHALL be 0.
REQ-025 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable.
REQ-026 Simultaneous push and pop in the same cycle (not full) SHALL leave count unchanged and advance both pointers.
REQ-027 sat_count SHALL increment by 1 on each accept where any component saturated, and SHALL stick at 0xFFFF (no wrap).

Reset
REQ-028 When rst is low at a rising edge, pointers, count, idx and sat_count SHALL clear to 0. This applies mid-stream as well, and any partially serialized entry SHALL be discarded.
REQ-029 During and after reset: out_valid = 0, in_ready = 1, and out_data, out_idx, out_last, sat_flag = 0. FIFO storage contents need not be cleared.
REQ-030 An in_valid asserted in a cycle where rst is low SHALL NOT be accepted.

Verification
REQ-031 Rounding (FRAC=14), one quaternion {0x00004000, 0x00002000, 0xFFFFE000, 0xFFFFDFFF}, out_ready=1 -> out_data 1, 1, 0, -1 with out_idx 0..3; out_last only on idx 3; sat_flag 0.
REQ-032 Saturation: q0=0x7FFFFFFF, q1=0x80000000, q2=0, q3=0x1FFFC000 -> out_data 32767 (sat_flag 1), -32768 (sat_flag 1), 0, 32767 (sat_flag 0); sat_count becomes 1.
REQ-033 Full/backpressure (DEPTH=4): hold out_ready=0 and push 5 consecutive valid quaternions -> 4 accepted, in_ready low after the 4th accept. Then out_ready=1 -> 16 beats in order, in_ready high again after beat 4.
REQ-034 Stall: toggle out_ready 1,0,0,1 mid-entry -> out_data/out_idx frozen while out_ready=0, and no beat is lost or duplicated.
REQ-035 Reset mid-operation: assert rst for 1 cycle after beat idx 1 of a 2-entry backlog -> next cycle out_valid=0, in_ready=1, sat_count=0; a new quaternion then emerges starting at idx 0.
REQ-036 Concurrent push/pop at count=3, in the same cycle as the idx-3 pop -> count stays 3, and pointer wrap past DEPTH-1 preserves order.
